// File: rtl/polmul_mac_seq_pkg.sv
// Shared types and helpers for the secret-by-public polynomial multiply sequencer.
package polmul_mac_seq_pkg;

    localparam int COEF_W = 13;
    localparam int SEC_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        OUT
    } state_e;

    // Sign-magnitude negation: flip the sign bit, keep the magnitude.
    function automatic logic [SEC_W-1:0] sm_negate(input logic [SEC_W-1:0] s);
        return {~s[SEC_W-1], s[SEC_W-2:0]};
    endfunction

endpackage

// File: rtl/polmul_mac_seq_if.sv
// Bundle of control, coefficient-memory and result-stream signals of polmul_mac_seq.
// The accumulate request only exists when POLMUL_ACCUMULATE_EN is defined.
interface polmul_mac_seq_if #(parameter int N = 256) ();
    import polmul_mac_seq_pkg::*;

    localparam int AW = $clog2(N);

    logic              start;
`ifdef POLMUL_ACCUMULATE_EN
    logic              accumulate;
`endif
    logic              busy;
    logic              done;
    logic [AW-1:0]     s_addr;
    logic [SEC_W-1:0]  s_rdata;
    logic [AW-1:0]     a_addr;
    logic [COEF_W-1:0] a_rdata;
    logic              c_valid;
    logic              c_ready;
    logic [COEF_W-1:0] c_data;
    logic [AW-1:0]     c_index;

    // Sequencer side.
    modport slave (
`ifdef POLMUL_ACCUMULATE_EN
        input  accumulate,
`endif
        input  start, s_rdata, a_rdata, c_ready,
        output busy, done, s_addr, a_addr, c_valid, c_data, c_index
    );

    // Decoder / memory / consumer side.
    modport master (
`ifdef POLMUL_ACCUMULATE_EN
        output accumulate,
`endif
        output start, s_rdata, a_rdata, c_ready,
        input  busy, done, s_addr, a_addr, c_valid, c_data, c_index
    );

endinterface

// File: rtl/polmul_mac_seq_lane.sv
// One accumulate lane: acc register with a shift-add multiply by a small
// sign-magnitude secret and an add/subtract, plus a rotate path for draining.
module polmul_lane
    import polmul_mac_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              mac_en,
    input  logic              rot_en,
    input  logic [COEF_W-1:0] acc_next,
    input  logic [SEC_W-1:0]  sec,
    input  logic [COEF_W-1:0] a,
    output logic [COEF_W-1:0] acc
);

    logic [COEF_W-1:0] a_x2;
    logic [COEF_W-1:0] a_x4;
    logic [COEF_W-1:0] prod;

    assign a_x2 = {a[COEF_W-2:0], 1'b0};
    assign a_x4 = {a[COEF_W-3:0], 2'b00};

    // Magnitudes above 4 all use the x5 term; magnitude 0 (including -0) yields 0.
    always_comb begin
        prod = '0;
        case (sec[SEC_W-2:0])
            3'd1:                prod = a;
            3'd2:                prod = a_x2;
            3'd3:                prod = a_x2 + a;
            3'd4:                prod = a_x4;
            3'd5, 3'd6, 3'd7:    prod = a_x4 + a;
            default:             prod = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= sec[SEC_W-1] ? (acc - prod) : (acc + prod);
        end else if (rot_en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/polmul_mac_seq.sv
// Sequencer computing c = a*s mod (x^N+1, 2^13): load s, stream a through N lanes,
// drain c over valid/ready. Define POLMUL_ACCUMULATE_EN to add the accumulate request.
module polmul_mac_seq
    import polmul_mac_seq_pkg::*;
#(
    parameter int N = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    polmul_mac_seq_if.slave     bus
);

    localparam int AW = $clog2(N);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              shift_q;
    logic              mac_q;
    logic              clear;
    logic              keep;
    logic              last;
    logic              c_valid;
    logic              xfer;
    logic [SEC_W-1:0]  sreg_q [N];
    logic [COEF_W-1:0] acc [N];

`ifdef POLMUL_ACCUMULATE_EN
    assign keep = bus.accumulate;
`else
    assign keep = 1'b0;
`endif

    assign last    = (cnt_q == AW'(N - 1));
    // The cycle after MAC issuing ends still carries the final lane update.
    assign c_valid = (state_q == OUT) && !mac_q;
    assign xfer    = c_valid && bus.c_ready;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    clear   = !keep;
                end
            end
            LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = MAC;
            end
            MAC: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = OUT;
            end
            OUT: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            shift_q <= 1'b0;
            mac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            shift_q <= (state_q == LOAD);
            mac_q   <= (state_q == MAC);
        end
    end

    // NOTE: the sreg array is reset on purpose; a reset must leave no stale secret behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) sreg_q[k] <= '0;
        end else if (shift_q) begin
            for (int k = 0; k < N - 1; k++) sreg_q[k] <= sreg_q[k+1];
            sreg_q[N-1] <= bus.s_rdata;
        end else if (mac_q) begin
            // Negacyclic rotate: the element wrapping to index 0 changes sign.
            sreg_q[0] <= sm_negate(sreg_q[N-1]);
            for (int k = 1; k < N; k++) sreg_q[k] <= sreg_q[k-1];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        polmul_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .mac_en   (mac_q),
            .rot_en   (xfer),
            .acc_next (acc[(k + 1) % N]),
            .sec      (sreg_q[k]),
            .a        (bus.a_rdata),
            .acc      (acc[k])
        );
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.s_addr  = (state_q == LOAD) ? cnt_q : '0;
    assign bus.a_addr  = (state_q == MAC)  ? cnt_q : '0;
    assign bus.c_valid = c_valid;
    assign bus.c_data  = acc[0];
    assign bus.c_index = (state_q == OUT) ? cnt_q : '0;

endmodule
